// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared constants and types for the VGA scan-out engine.
//   - Standard timing sets for 640x480@60 and 800x600@60, in pixel ticks and lines.
//   - Sync polarity constants.
//   - Colour width and packed pixel struct.
//   - The control word that travels down the read-latency delay line.
//   - A small helper that turns an "in sync region" flag into a pin level.
// ---------------------------------------------------------------------------
package vga_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs active-low
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs active-high
    localparam int VGA800_H_ACTIVE = 800;
    localparam int VGA800_H_FP     = 40;
    localparam int VGA800_H_SYNC   = 128;
    localparam int VGA800_H_BP     = 88;
    localparam int VGA800_V_ACTIVE = 600;
    localparam int VGA800_V_FP     = 1;
    localparam int VGA800_V_SYNC   = 4;
    localparam int VGA800_V_BP     = 23;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    localparam int DEFAULT_COLOR_W = 8;
    localparam int MAX_PIX_DIV     = 16;
    localparam int MAX_RD_LAT      = 4;

    typedef struct packed {
        logic [DEFAULT_COLOR_W-1:0] r;
        logic [DEFAULT_COLOR_W-1:0] g;
        logic [DEFAULT_COLOR_W-1:0] b;
    } rgb8_t;

    // Per-pixel control that must stay aligned with the framebuffer data
    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
        logic first;
    } scan_ctl_t;

    function automatic logic sync_level(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_scan_engine_if.sv
// ---------------------------------------------------------------------------
// vga_scan_engine_if
//   Bundles the framebuffer side and VGA pin side of the scan engine.
//   slave  : the engine (takes en + pixel data, drives addresses and pins)
//   master : the system side (drives en + pixel data, observes the rest)
//   Names are from the engine's point of view (i_ = into engine, o_ = out).
// ---------------------------------------------------------------------------
interface vga_scan_engine_if
    import vga_pkg::*;
#(
    parameter int COLOR_W = DEFAULT_COLOR_W,
    parameter int ADDR_W  = 10,
    parameter int FB_AW   = 19
);
    logic                   i_en;
    logic [3*COLOR_W-1:0]   i_vga_data;
    logic [ADDR_W-1:0]      o_h_addr;
    logic [ADDR_W-1:0]      o_v_addr;
    logic [FB_AW-1:0]       o_fb_addr;
    logic                   o_rd_en;
    logic                   o_hsync;
    logic                   o_vsync;
    logic                   o_valid;
    logic [COLOR_W-1:0]     o_vga_r;
    logic [COLOR_W-1:0]     o_vga_g;
    logic [COLOR_W-1:0]     o_vga_b;
    logic                   o_frame_start;

    modport slave (
        input  i_en, i_vga_data,
        output o_h_addr, o_v_addr, o_fb_addr, o_rd_en,
        output o_hsync, o_vsync, o_valid, o_vga_r, o_vga_g, o_vga_b, o_frame_start
    );

    modport master (
        output i_en, i_vga_data,
        input  o_h_addr, o_v_addr, o_fb_addr, o_rd_en,
        input  o_hsync, o_vsync, o_valid, o_vga_r, o_vga_g, o_vga_b, o_frame_start
    );

endinterface

// File: rtl/vga_delay_line.sv
// ---------------------------------------------------------------------------
// vga_delay_line
//   Enabled shift register, DEPTH stages of WIDTH bits. DEPTH = 0 is a wire.
//   clk, reset : system clock, synchronous active-high clear of all stages
//   i_en       : shift strobe (one pixel tick)
//   i_d / o_q  : input word / word delayed by DEPTH strobes
// ---------------------------------------------------------------------------
module vga_delay_line #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_wire
            // clk/reset/en have no job with zero depth
            logic w_unused;
            assign w_unused = ^{clk, reset, i_en};
            assign o_q      = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
                end else if (i_en) begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_engine.sv
// ---------------------------------------------------------------------------
// vga_scan_engine
//   Parametrised VGA raster timing generator and framebuffer scan-out.
//   clk, reset : system clock, synchronous active-high reset
//   bus.i_en        : scan enable, low freezes everything
//   bus.i_vga_data  : {r,g,b} from framebuffer, RD_LAT ticks after address
//   bus.o_h/v_addr, o_fb_addr, o_rd_en : registered read address stage
//   bus.o_hsync/vsync/valid/vga_r/g/b/frame_start : registered pin stage,
//                     RD_LAT+1 ticks behind the address stage
// ---------------------------------------------------------------------------
module vga_scan_engine
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = VGA640_H_ACTIVE,
    parameter int   H_FP     = VGA640_H_FP,
    parameter int   H_SYNC   = VGA640_H_SYNC,
    parameter int   H_BP     = VGA640_H_BP,
    parameter int   V_ACTIVE = VGA640_V_ACTIVE,
    parameter int   V_FP     = VGA640_V_FP,
    parameter int   V_SYNC   = VGA640_V_SYNC,
    parameter int   V_BP     = VGA640_V_BP,
    parameter logic HS_POL   = SYNC_ACTIVE_LOW,
    parameter logic VS_POL   = SYNC_ACTIVE_LOW,
    parameter int   PIX_DIV  = 1,
    parameter int   RD_LAT   = 1,
    parameter int   COLOR_W  = DEFAULT_COLOR_W,
    parameter int   ADDR_W   = 10,
    parameter int   FB_AW    = 19
) (
    input  logic             clk,
    input  logic             reset,
    vga_scan_engine_if.slave bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL + 1);
    localparam int VC_W    = $clog2(V_TOTAL + 1);
    localparam int DIV_W   = $clog2(MAX_PIX_DIV);

    logic [DIV_W-1:0]   r_div;
    logic [HC_W-1:0]    r_h_cnt;
    logic [VC_W-1:0]    r_v_cnt;

    logic [ADDR_W-1:0]  r_h_addr;
    logic [ADDR_W-1:0]  r_v_addr;
    logic [FB_AW-1:0]   r_fb_addr;
    logic [FB_AW-1:0]   r_fb_next;
    logic               r_rd_en;
    scan_ctl_t          r_ctl;
    scan_ctl_t          w_ctl_d;

    logic               r_hsync;
    logic               r_vsync;
    logic               r_valid;
    logic [COLOR_W-1:0] r_vga_r;
    logic [COLOR_W-1:0] r_vga_g;
    logic [COLOR_W-1:0] r_vga_b;
    logic               r_frame_start;

    logic w_tick;
    logic w_h_last;
    logic w_v_last;
    logic w_active;
    logic w_hs;
    logic w_vs;
    logic w_first;

    // en gates the tick itself, so every stage below freezes without extra logic
    assign w_tick   = bus.i_en && (r_div == DIV_W'(PIX_DIV - 1));
    assign w_h_last = (r_h_cnt == HC_W'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == VC_W'(V_TOTAL - 1));
    assign w_active = (r_h_cnt < HC_W'(H_ACTIVE)) && (r_v_cnt < VC_W'(V_ACTIVE));
    assign w_hs     = (r_h_cnt >= HC_W'(H_ACTIVE + H_FP)) &&
                      (r_h_cnt <  HC_W'(H_ACTIVE + H_FP + H_SYNC));
    assign w_vs     = (r_v_cnt >= VC_W'(V_ACTIVE + V_FP)) &&
                      (r_v_cnt <  VC_W'(V_ACTIVE + V_FP + V_SYNC));
    assign w_first  = (r_h_cnt == '0) && (r_v_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div   <= '0;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_tick) begin
            r_div   <= '0;
            r_h_cnt <= w_h_last ? '0 : r_h_cnt + HC_W'(1);
            if (w_h_last) r_v_cnt <= w_v_last ? '0 : r_v_cnt + VC_W'(1);
        end else if (bus.i_en) begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Address stage. fb_addr walks a running pointer instead of multiplying
    // v*H_ACTIVE; the pointer only resets on the last count of the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_addr  <= '0;
            r_v_addr  <= '0;
            r_fb_addr <= '0;
            r_fb_next <= '0;
            r_rd_en   <= 1'b0;
            r_ctl     <= '0;
        end else if (w_tick) begin
            r_rd_en   <= w_active;
            r_h_addr  <= w_active ? ADDR_W'(r_h_cnt) : '0;
            r_v_addr  <= w_active ? ADDR_W'(r_v_cnt) : '0;
            r_fb_addr <= w_active ? r_fb_next : '0;
            if (w_h_last && w_v_last) r_fb_next <= '0;
            else if (w_active)        r_fb_next <= r_fb_next + FB_AW'(1);
            r_ctl     <= '{hs: w_hs, vs: w_vs, active: w_active, first: w_first && w_active};
        end
    end

    vga_delay_line #(
        .WIDTH ($bits(scan_ctl_t)),
        .DEPTH (RD_LAT)
    ) u_ctl_delay (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_tick),
        .i_d   (r_ctl),
        .o_q   (w_ctl_d)
    );

    // Pin stage: samples memory data on the tick that completes the delay.
    // frame_start drops on the first non-tick clk so it is one clk wide
    // regardless of PIX_DIV or en.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_valid       <= 1'b0;
            r_vga_r       <= '0;
            r_vga_g       <= '0;
            r_vga_b       <= '0;
            r_frame_start <= 1'b0;
        end else if (w_tick) begin
            r_hsync       <= sync_level(w_ctl_d.hs, HS_POL);
            r_vsync       <= sync_level(w_ctl_d.vs, VS_POL);
            r_valid       <= w_ctl_d.active;
            r_vga_r       <= w_ctl_d.active ? bus.i_vga_data[3*COLOR_W-1 -: COLOR_W] : '0;
            r_vga_g       <= w_ctl_d.active ? bus.i_vga_data[2*COLOR_W-1 -: COLOR_W] : '0;
            r_vga_b       <= w_ctl_d.active ? bus.i_vga_data[COLOR_W-1   -: COLOR_W] : '0;
            r_frame_start <= w_ctl_d.first;
        end else begin
            r_frame_start <= 1'b0;
        end
    end

    assign bus.o_h_addr      = r_h_addr;
    assign bus.o_v_addr      = r_v_addr;
    assign bus.o_fb_addr     = r_fb_addr;
    assign bus.o_rd_en       = r_rd_en;
    assign bus.o_hsync       = r_hsync;
    assign bus.o_vsync       = r_vsync;
    assign bus.o_valid       = r_valid;
    assign bus.o_vga_r       = r_vga_r;
    assign bus.o_vga_g       = r_vga_g;
    assign bus.o_vga_b       = r_vga_b;
    assign bus.o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scan_engine.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_engine
//   Three engines share clock, reset and en:
//   dutA : default 640x480 timing, RD_LAT=1, PIX_DIV=1, one-stage memory
//   dutB : 16x6 visible / 25x11 total, RD_LAT=2, two-stage memory
//   dutC : same small raster, PIX_DIV=2, RD_LAT=0, active-high syncs
// ---------------------------------------------------------------------------
module tb_vga_scan_engine;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic en;

    int nVectors     = 0;
    int nMiscompares = 0;

    always #5 clk = ~clk;

    vga_scan_engine_if busA ();
    vga_scan_engine_if busB ();
    vga_scan_engine_if busC ();

    vga_scan_engine dutA (.clk(clk), .reset(reset), .bus(busA));

    vga_scan_engine #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(2),
        .RD_LAT(2)
    ) dutB (.clk(clk), .reset(reset), .bus(busB));

    vga_scan_engine #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIX_DIV(2), .RD_LAT(0)
    ) dutC (.clk(clk), .reset(reset), .bus(busC));

    // Framebuffer models
    logic [23:0] memA, memB1, memB2;
    logic [23:0] rgbA, rgbB, rgbC;

    always @(posedge clk) begin
        if (en) begin
            memA  <= {busA.o_fb_addr[7:0], busA.o_fb_addr[15:8], 8'h3C};
            memB1 <= {4'h0, busB.o_fb_addr[3:0], busB.o_fb_addr[11:4], 8'hA5};
            memB2 <= memB1;
        end
    end

    assign busA.i_en       = en;
    assign busB.i_en       = en;
    assign busC.i_en       = en;
    assign busA.i_vga_data = memA;
    assign busB.i_vga_data = memB2;
    assign busC.i_vga_data = {4'h0, busC.o_fb_addr[3:0], busC.o_fb_addr[11:4], 8'h5A};

    assign rgbA = {busA.o_vga_r, busA.o_vga_g, busA.o_vga_b};
    assign rgbB = {busB.o_vga_r, busB.o_vga_g, busB.o_vga_b};
    assign rgbC = {busC.o_vga_r, busC.o_vga_g, busC.o_vga_b};

    // Reset idle state and first-pixel latency on the default engine
    task automatic test_reset();
        int cyc;
        bit seen;
        reset = 1'b1;
        en    = 1'b1;
        repeat (5) @(negedge clk);
        nVectors++;
        if (busA.o_hsync !== 1'b1 || busA.o_vsync !== 1'b1) begin
            nMiscompares++;
            $display("[TB] FAIL reset_sync: got hs=%b vs=%b, expected hs=1 vs=1", busA.o_hsync, busA.o_vsync);
        end
        nVectors++;
        if (busA.o_valid !== 1'b0 || rgbA !== 24'h0 || busA.o_frame_start !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_pix: got valid=%b rgb=%h fs=%b, expected 0/000000/0", busA.o_valid, rgbA, busA.o_frame_start);
        end
        nVectors++;
        if (busA.o_h_addr !== '0 || busA.o_v_addr !== '0 || busA.o_fb_addr !== '0 || busA.o_rd_en !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_addr: got h=%0d v=%0d fb=%0d rd=%b, expected all 0", busA.o_h_addr, busA.o_v_addr, busA.o_fb_addr, busA.o_rd_en);
        end
        nVectors++;
        if (busC.o_hsync !== 1'b0 || busC.o_vsync !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_pol_high: got hs=%b vs=%b, expected 0/0", busC.o_hsync, busC.o_vsync);
        end
        reset = 1'b0;
        seen  = 1'b0;
        cyc   = 0;
        for (int i = 1; i <= 10 && !seen; i++) begin
            @(negedge clk);
            if (busA.o_valid === 1'b1) begin
                seen = 1'b1;
                cyc  = i;
            end else begin
                nVectors++;
                if (busA.o_hsync !== 1'b1 || busA.o_vsync !== 1'b1 || rgbA !== 24'h0) begin
                    nMiscompares++;
                    $display("[TB] FAIL pre_active: got hs=%b vs=%b rgb=%h, expected 1/1/000000", busA.o_hsync, busA.o_vsync, rgbA);
                end
            end
        end
        nVectors++;
        if (cyc !== 3) begin
            nMiscompares++;
            $display("[TB] FAIL first_valid_latency: got %0d clks, expected 3", cyc);
        end
        nVectors++;
        if (busA.o_frame_start !== 1'b1 || rgbA !== 24'h00003C) begin
            nMiscompares++;
            $display("[TB] FAIL first_pixel: got fs=%b rgb=%h, expected 1/00003c", busA.o_frame_start, rgbA);
        end
    endtask

    // Default line timing measured from the first visible pixel
    task automatic test_line_timing();
        int hsFall, hsLow, validCnt, nextRise;
        logic prevValid;
        hsFall    = -1;
        hsLow     = 0;
        validCnt  = 1;
        nextRise  = -1;
        prevValid = 1'b1;
        for (int c = 1; c <= 850; c++) begin
            @(negedge clk);
            if (c < 800) begin
                if (busA.o_valid === 1'b1) validCnt++;
                if (busA.o_hsync === 1'b0) begin
                    hsLow++;
                    if (hsFall < 0) hsFall = c;
                end
            end
            if (nextRise < 0 && busA.o_valid === 1'b1 && prevValid === 1'b0) nextRise = c;
            if (c == 639) begin
                nVectors++;
                if (rgbA !== 24'h7F023C) begin
                    nMiscompares++;
                    $display("[TB] FAIL last_pixel_line0: got %h, expected 7f023c", rgbA);
                end
            end
            if (c == 800) begin
                nVectors++;
                if (rgbA !== 24'h80023C) begin
                    nMiscompares++;
                    $display("[TB] FAIL first_pixel_line1: got %h, expected 80023c", rgbA);
                end
            end
            prevValid = busA.o_valid;
        end
        nVectors++;
        if (hsFall !== 656) begin
            nMiscompares++;
            $display("[TB] FAIL hsync_fall: got %0d, expected 656", hsFall);
        end
        nVectors++;
        if (hsLow !== 96) begin
            nMiscompares++;
            $display("[TB] FAIL hsync_width: got %0d, expected 96", hsLow);
        end
        nVectors++;
        if (validCnt !== 640) begin
            nMiscompares++;
            $display("[TB] FAIL valid_per_line: got %0d, expected 640", validCnt);
        end
        nVectors++;
        if (nextRise !== 800) begin
            nMiscompares++;
            $display("[TB] FAIL line_period: got %0d, expected 800", nextRise);
        end
    endtask

    // Full small frame with RD_LAT=2: every clk checked against the raster model
    task automatic test_frame();
        int line, col;
        logic expVal, expHs, expVs;
        logic [23:0] expRgb;
        bit found, seenLast;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (busB.o_frame_start === 1'b1) found = 1'b1;
        end
        nVectors++;
        if (!found) begin
            nMiscompares++;
            $display("[TB] FAIL frame_start_timeout_B: got none in 600 clks, expected one");
        end
        seenLast = 1'b0;
        for (int c = 0; c < 275; c++) begin
            if (c > 0) @(negedge clk);
            line   = c / 25;
            col    = c % 25;
            expVal = (line < 6) && (col < 16);
            expHs  = !((col >= 18) && (col < 21));
            expVs  = !((line >= 7) && (line < 9));
            expRgb = expVal ? {8'(col), 8'(line), 8'hA5} : 24'h0;
            nVectors++;
            if (busB.o_valid !== expVal || busB.o_hsync !== expHs || busB.o_vsync !== expVs ||
                rgbB !== expRgb || busB.o_frame_start !== (c == 0)) begin
                nMiscompares++;
                $display("[TB] FAIL frame_B c=%0d: got v=%b hs=%b vs=%b rgb=%h fs=%b, expected v=%b hs=%b vs=%b rgb=%h fs=%b",
                         c, busB.o_valid, busB.o_hsync, busB.o_vsync, rgbB, busB.o_frame_start,
                         expVal, expHs, expVs, expRgb, (c == 0));
            end
            if (busB.o_rd_en === 1'b1 && busB.o_h_addr == 10'd15 && busB.o_v_addr == 10'd5) begin
                seenLast = 1'b1;
                nVectors++;
                if (busB.o_fb_addr !== 19'd95) begin
                    nMiscompares++;
                    $display("[TB] FAIL last_fb_addr: got %0d, expected 95", busB.o_fb_addr);
                end
            end
        end
        @(negedge clk);
        nVectors++;
        if (busB.o_frame_start !== 1'b1) begin
            nMiscompares++;
            $display("[TB] FAIL frame_period_B: got fs=%b at +275, expected 1", busB.o_frame_start);
        end
        nVectors++;
        if (!seenLast) begin
            nMiscompares++;
            $display("[TB] FAIL last_addr_seen: got 0, expected 1");
        end
    endtask

    // PIX_DIV=2: doubled periods, held addresses, one-clk frame_start
    task automatic test_pixdiv();
        int pix, line, col, apix, aline, acol;
        logic expVal, expHs, expVs, aAct;
        logic [23:0] expRgb;
        logic [9:0]  expH, expV;
        logic [18:0] expFb;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (busC.o_frame_start === 1'b1) found = 1'b1;
        end
        nVectors++;
        if (!found) begin
            nMiscompares++;
            $display("[TB] FAIL frame_start_timeout_C: got none in 600 clks, expected one");
        end
        for (int c = 0; c < 550; c++) begin
            if (c > 0) @(negedge clk);
            pix    = c / 2;
            line   = pix / 25;
            col    = pix % 25;
            expVal = (line < 6) && (col < 16);
            expHs  = (col >= 18) && (col < 21);
            expVs  = (line >= 7) && (line < 9);
            expRgb = expVal ? {8'(col), 8'(line), 8'h5A} : 24'h0;
            apix   = (c / 2 + 1) % 275;
            aline  = apix / 25;
            acol   = apix % 25;
            aAct   = (aline < 6) && (acol < 16);
            expH   = aAct ? 10'(acol) : 10'd0;
            expV   = aAct ? 10'(aline) : 10'd0;
            expFb  = aAct ? 19'(aline * 16 + acol) : 19'd0;
            nVectors++;
            if (busC.o_valid !== expVal || busC.o_hsync !== expHs || busC.o_vsync !== expVs ||
                rgbC !== expRgb || busC.o_frame_start !== (c == 0)) begin
                nMiscompares++;
                $display("[TB] FAIL pixdiv_pins c=%0d: got v=%b hs=%b vs=%b rgb=%h fs=%b, expected v=%b hs=%b vs=%b rgb=%h fs=%b",
                         c, busC.o_valid, busC.o_hsync, busC.o_vsync, rgbC, busC.o_frame_start,
                         expVal, expHs, expVs, expRgb, (c == 0));
            end
            nVectors++;
            if (busC.o_h_addr !== expH || busC.o_v_addr !== expV || busC.o_fb_addr !== expFb || busC.o_rd_en !== aAct) begin
                nMiscompares++;
                $display("[TB] FAIL pixdiv_addr c=%0d: got h=%0d v=%0d fb=%0d rd=%b, expected h=%0d v=%0d fb=%0d rd=%b",
                         c, busC.o_h_addr, busC.o_v_addr, busC.o_fb_addr, busC.o_rd_en, expH, expV, expFb, aAct);
            end
        end
        @(negedge clk);
        nVectors++;
        if (busC.o_frame_start !== 1'b1) begin
            nMiscompares++;
            $display("[TB] FAIL frame_period_C: got fs=%b at +550, expected 1", busC.o_frame_start);
        end
    endtask

    // en low for 10 clks while pixel x=10 is on the pins
    task automatic test_enable_hold();
        logic [23:0] sRgb;
        logic [9:0]  sH, sV;
        logic [18:0] sFb;
        logic        sHs, sVs;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (busB.o_valid === 1'b1 && busB.o_vga_r === 8'd10) found = 1'b1;
        end
        nVectors++;
        if (!found) begin
            nMiscompares++;
            $display("[TB] FAIL en_find_x10: got none in 600 clks, expected one");
        end
        sRgb = rgbB;
        sH   = busB.o_h_addr;
        sV   = busB.o_v_addr;
        sFb  = busB.o_fb_addr;
        sHs  = busB.o_hsync;
        sVs  = busB.o_vsync;
        nVectors++;
        if (sH !== 10'd13) begin
            nMiscompares++;
            $display("[TB] FAIL addr_lead: got h_addr=%0d, expected 13", sH);
        end
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            nVectors++;
            if (rgbB !== sRgb || busB.o_valid !== 1'b1 || busB.o_h_addr !== sH || busB.o_v_addr !== sV ||
                busB.o_fb_addr !== sFb || busB.o_hsync !== sHs || busB.o_vsync !== sVs) begin
                nMiscompares++;
                $display("[TB] FAIL en_freeze %0d: got rgb=%h v=%b h=%0d fb=%0d, expected rgb=%h v=1 h=%0d fb=%0d",
                         i, rgbB, busB.o_valid, busB.o_h_addr, busB.o_fb_addr, sRgb, sH, sFb);
            end
        end
        en = 1'b1;
        @(negedge clk);
        nVectors++;
        if (busB.o_valid !== 1'b1 || rgbB !== {8'd11, sRgb[15:8], 8'hA5}) begin
            nMiscompares++;
            $display("[TB] FAIL en_resume_pix: got v=%b rgb=%h, expected v=1 rgb=%h", busB.o_valid, rgbB, {8'd11, sRgb[15:8], 8'hA5});
        end
        nVectors++;
        if (busB.o_h_addr !== 10'd14 || busB.o_fb_addr !== sFb + 19'd1) begin
            nMiscompares++;
            $display("[TB] FAIL en_resume_addr: got h=%0d fb=%0d, expected h=14 fb=%0d", busB.o_h_addr, busB.o_fb_addr, sFb + 19'd1);
        end
    endtask

    // One-clk reset in the middle of line 3, then a clean restart at (0,0)
    task automatic test_reset_midframe();
        int cyc;
        bit found, seen;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (busB.o_valid === 1'b1 && busB.o_vga_r === 8'd5 && busB.o_vga_g === 8'd3) found = 1'b1;
        end
        nVectors++;
        if (!found) begin
            nMiscompares++;
            $display("[TB] FAIL rst_find_pixel: got none in 600 clks, expected (5,3)");
        end
        reset = 1'b1;
        @(negedge clk);
        nVectors++;
        if (busB.o_valid !== 1'b0 || rgbB !== 24'h0 || busB.o_hsync !== 1'b1 || busB.o_vsync !== 1'b1 ||
            busB.o_h_addr !== '0 || busB.o_v_addr !== '0 || busB.o_fb_addr !== '0 ||
            busB.o_rd_en !== 1'b0 || busB.o_frame_start !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL midframe_reset: got v=%b rgb=%h hs=%b vs=%b h=%0d v=%0d fb=%0d rd=%b, expected idle",
                     busB.o_valid, rgbB, busB.o_hsync, busB.o_vsync, busB.o_h_addr, busB.o_v_addr, busB.o_fb_addr, busB.o_rd_en);
        end
        reset = 1'b0;
        seen  = 1'b0;
        cyc   = 0;
        for (int i = 1; i <= 10 && !seen; i++) begin
            @(negedge clk);
            if (busB.o_valid === 1'b1) begin
                seen = 1'b1;
                cyc  = i;
            end else begin
                nVectors++;
                if (rgbB !== 24'h0 || busB.o_frame_start !== 1'b0) begin
                    nMiscompares++;
                    $display("[TB] FAIL post_reset_blank: got rgb=%h fs=%b, expected 000000/0", rgbB, busB.o_frame_start);
                end
            end
        end
        nVectors++;
        if (cyc !== 4) begin
            nMiscompares++;
            $display("[TB] FAIL restart_latency: got %0d clks, expected 4", cyc);
        end
        nVectors++;
        if (busB.o_frame_start !== 1'b1 || rgbB !== 24'h0000A5) begin
            nMiscompares++;
            $display("[TB] FAIL restart_pixel: got fs=%b rgb=%h, expected 1/0000a5", busB.o_frame_start, rgbB);
        end
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            nVectors++;
            if (busB.o_valid !== 1'b1 || rgbB !== {8'(i), 8'h00, 8'hA5} || busB.o_frame_start !== 1'b0) begin
                nMiscompares++;
                $display("[TB] FAIL restart_line0 x=%0d: got v=%b rgb=%h fs=%b, expected v=1 rgb=%h fs=0",
                         i, busB.o_valid, rgbB, busB.o_frame_start, {8'(i), 8'h00, 8'hA5});
            end
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame();
        test_pixdiv();
        test_enable_hold();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

    // Guards against a stuck run; every task wait is already bounded
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, expected summary before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
